// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   // Latency down-counter width; covers MEM_LAT up to 7.
   localparam int unsigned LAT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous memory between the fetch (IF) and
// data (DM) ports, with starvation relief for IF and a sticky halt.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              halt_req,
   output logic              halted
);

   localparam int unsigned     STV_W    = $clog2(STARVE_MAX + 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

   state_e             state;
   gnt_e               gnt;
   gnt_e               gnt_sel_c;
   logic               acc_we;
   logic               halt_pend;
   logic [LAT_W-1:0]   lat_cnt;
   logic [STV_W-1:0]   starve_cnt;

   // DM wins unless it is idle or IF has been passed over STARVE_MAX times.
   always_comb begin
      gnt_sel_c = GNT_DM;
      if (if_req && (!dm_req || (starve_cnt == STV_MAX))) begin
         gnt_sel_c = GNT_IF;
      end
   end

   // Arbiter FSM: grant/issue in IDLE, count latency and ack in BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         gnt        <= GNT_IF;
         acc_we     <= 1'b0;
         halt_pend  <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         if_ack     <= 1'b0;
         if_rdata   <= '0;
         dm_ack     <= 1'b0;
         dm_rdata   <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         halted     <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (halt_req) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end else if (if_req || dm_req) begin
                  state     <= ST_BUSY;
                  mem_en    <= 1'b1;
                  lat_cnt   <= LAT_LOAD;
                  halt_pend <= 1'b0;
                  gnt       <= gnt_sel_c;
                  if (gnt_sel_c == GNT_IF) begin
                     acc_we     <= 1'b0;
                     mem_addr   <= if_addr;
                     starve_cnt <= '0;
                  end else begin
                     acc_we    <= dm_we;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     if (if_req && (starve_cnt != STV_MAX)) begin
                        starve_cnt <= starve_cnt + STV_W'(1);
                     end
                  end
               end
            end
            ST_BUSY: begin
               if (halt_req) begin
                  halt_pend <= 1'b1;
               end
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
                  if (lat_cnt == LAT_W'(1)) begin
                     if (gnt == GNT_IF) begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                     end else begin
                        dm_ack <= 1'b1;
                        if (!acc_we) begin
                           dm_rdata <= mem_rdata;
                        end
                     end
                  end
               end else if (halt_pend || halt_req) begin
                  // Ack cycle is over; a pending halt wins over returning to IDLE.
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MEM_LAT = 2, STARVE_MAX = 3).
module tb_mem_port_arbiter;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam int unsigned MEM_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          halt_req;
   logic          halted;

   int n_asserts = 0;
   int n_fail    = 0;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .halt_req(halt_req), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until mem_en is seen; c = cycles advanced (budget+1 on timeout).
   task automatic wait_en(output int c);
      c = 0;
      do begin
         tick();
         c++;
      end while (!mem_en && c <= 30);
   endtask

   task automatic wait_ack(input bit is_dm, output int c);
      c = 0;
      do begin
         tick();
         c++;
      end while (!(is_dm ? dm_ack : if_ack) && c <= 30);
   endtask

   // One isolated access from a single requester.
   task automatic do_txn(input vec_t v, input string tag);
      int c;
      mem_rdata = v.rdata;
      if (v.is_dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      wait_en(c);
      chk({tag, " en_latency"}, 32'(c), 32'd1);
      chk({tag, " mem_addr"}, mem_addr, v.addr);
      chk({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
      if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
      tick();
      chk({tag, " en_single_cycle"}, {30'd0, mem_en, mem_we}, 32'd0);
      wait_ack(v.is_dm, c);
      chk({tag, " ack_latency"}, 32'(c + 1), 32'(MEM_LAT));
      dm_req = 1'b0;
      if_req = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
      chk({tag, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
      tick();
      chk({tag, " ack_pulse"}, {30'd0, if_ack, dm_ack}, 32'd0);
      chk({tag, " rdata_hold"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
      tick();
   endtask

   initial begin
      int c;
      int n;
      logic [31:0] exp_gnt [6];

      //              is_dm we  addr         wdata        rdata        exp_rdata
      vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b0, 32'h24,  32'h0,        32'h12345678, 32'h12345678};
      vecs[2] = '{1'b1, 1'b1, 32'h20,  32'h55,       32'hA5A5A5A5, 32'h12345678};
      vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 1'b1, 32'h30,  32'hFFFF0000, 32'h11111111, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 32'h34,  32'h0,        32'h0BADF00D, 32'h0BADF00D};

      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; halt_req = 1'b0;
      #12;
      chk("reset outputs", {27'd0, if_ack, dm_ack, mem_en, mem_we, halted}, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset rdata", if_rdata | dm_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // Simultaneous requests: DM write first, then IF.
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
      mem_rdata = 32'h77777777;
      wait_en(c);
      chk("sim dm first addr", mem_addr, 32'h20);
      chk("sim dm we", 32'(mem_we), 32'd1);
      chk("sim dm wdata", mem_wdata, 32'h55);
      wait_ack(1'b1, c);
      chk("sim dm ack latency", 32'(c), 32'(MEM_LAT));
      dm_req = 1'b0; dm_we = 1'b0;
      chk("sim dm_rdata unchanged", dm_rdata, 32'h0BADF00D);
      wait_en(c);
      chk("sim if next latency", 32'(c), 32'd2);
      chk("sim if addr", mem_addr, 32'h40);
      chk("sim if we", 32'(mem_we), 32'd0);
      wait_ack(1'b0, c);
      chk("sim if ack latency", 32'(c), 32'(MEM_LAT));
      chk("sim if rdata", if_rdata, 32'h77777777);
      if_req = 1'b0;
      tick();

      // Starvation: three DM grants, then IF is forced, then DM wins again.
      exp_gnt[0] = 32'h200; exp_gnt[1] = 32'h200; exp_gnt[2] = 32'h200;
      exp_gnt[3] = 32'h100; exp_gnt[4] = 32'h200; exp_gnt[5] = 32'h100;
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      mem_rdata = 32'h3C3C3C3C;
      for (int g = 0; g < 6; g++) begin
         wait_en(c);
         if (g >= 1 && g <= 4) chk($sformatf("starve gap%0d", g), 32'(c), 32'(MEM_LAT + 2));
         chk($sformatf("starve grant%0d", g), mem_addr, exp_gnt[g]);
         if (g == 3) chk("starve_cnt cleared", 32'(dut.starve_cnt), 32'd0);
         if (g == 4) begin
            wait_ack(1'b1, c);
            chk("starve dm ack", 32'(dm_ack), 32'd1);
            dm_req = 1'b0;
         end
      end
      wait_ack(1'b0, c);
      chk("starve if ack", 32'(if_ack), 32'd1);
      if_req = 1'b0;
      tick();

      // Halt pulse while a DM read is in flight.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_rdata = 32'h600DCAFE;
      wait_en(c);
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt dm_ack delivered", 32'(dm_ack), 32'd1);
      chk("halt dm_rdata", dm_rdata, 32'h600DCAFE);
      chk("halt not yet", 32'(halted), 32'd0);
      dm_req = 1'b0;
      tick();
      chk("halted set", 32'(halted), 32'd1);
      if_req = 1'b1; if_addr = 32'h500;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n += int'(mem_en) + int'(if_ack) + int'(dm_ack);
      end
      chk("halted no traffic", 32'(n), 32'd0);
      chk("halted sticky", 32'(halted), 32'd1);
      if_req = 1'b0;

      // Reset releases halt; then reset in the middle of an access.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("post-halt reset", 32'(halted), 32'd0);
      if_req = 1'b1; if_addr = 32'h600; mem_rdata = 32'h12121212;
      wait_en(c);
      chk("mid en latency", 32'(c), 32'd1);
      tick();
      rst_n = 1'b0;
      if_req = 1'b0;
      #1;
      chk("mid reset outputs", {27'd0, if_ack, dm_ack, mem_en, mem_we, halted}, 32'd0);
      chk("mid reset mem_addr", mem_addr, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         n += int'(if_ack) + int'(dm_ack) + int'(mem_en);
      end
      chk("mid reset no ack", 32'(n), 32'd0);
      if_req = 1'b1; if_addr = 32'h700;
      tick();
      chk("after reset en", 32'(mem_en), 32'd1);
      chk("after reset addr", mem_addr, 32'h700);
      wait_ack(1'b0, c);
      chk("after reset ack", 32'(c), 32'(MEM_LAT));
      if_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter
